arq_link_ctrl: RTL
==================

# arq_link_ctrl

Parametrised per-link ARQ, SEQN and flow-control engine for the baseband link controller (Vol2 Part B 7.6), sitting between the packet header decoder and the TX header builder. It tracks up to NLINK logical transports independently. Each link has an automatic SEQN/retransmission state machine, so the MCU no longer toggles SEQN. An optional retransmit limit forces a zero-length continue packet when the limit is exceeded.

## Interface
Parameters:
- NLINK, 8, number of logical transports tracked (indices 0..NLINK-1)
- LTW, 3, width of LT_ADDR index fields
- RTXW, 4, retransmit counter width
- MAX_RTX, 15, retransmissions allowed before abort (must be ≤ 2^RTXW-1)

Ports:
- clk_6M  in  1  6 MHz baseband clock
- rst  in  1  synchronous, active-high reset
- conn_new_p  in  1  new connection on link conn_lt; reinitialises that link
- conn_lt  in  LTW  link index for conn_new_p
- tx_hdr_p  in  1  TX header build strobe for link tx_lt
- tx_lt  in  LTW  TX link index
- tx_data  in  1  TX packet type carries ACL data
- rx_done_p  in  1  RX payload decode complete for link rx_lt
- rx_lt  in  LTW  decoded LT_ADDR
- rx_hecgood, rx_crcgood, rx_addressed, rx_data  in  1 each  HEC ok, CRC/MIC ok, addressed to us, data packet type
- rx_seqn, rx_arqn, rx_flow  in  1 each  decoded header bits
- rx_bufempty  in  1  local ACL RX buffer empty
- flush_p  in  1  MCU flush request for link flush_lt
- flush_lt  in  LTW  link index for flush_p
- tx_vld  out  1  pulse: tx_* fields valid
- tx_mode  out  2  0 NONDATA, 1 NEW, 2 OLD (retransmit), 3 ZERO (zero-length continue)
- tx_arqn, tx_seqn, tx_flow  out  1 each  header bits for TX
- rx_accept_p, rx_ignore_p  out  1 each  payload accepted (new) / duplicate ignored
- rtx_abort_p  out  1  retransmit limit hit on link rtx_abort_lt
- rtx_abort_lt  out  LTW  index for rtx_abort_p
- link_arqn, link_seqn, link_seqn_old, link_flow_ok  out  NLINK each  per-link state vectors

## Operation
- Per-link state: IDLE (no outstanding payload), PEND (payload sent, awaiting ACK), FLUSH (send ZERO until ACK).
- TX, on tx_hdr_p, link L = tx_lt:
  - tx_data=0 → mode NONDATA; state unchanged.
  - IDLE → mode NEW, next state PEND, rtx_cnt=0.
  - PEND, rtx_cnt<MAX_RTX → mode OLD, rtx_cnt+1.
  - PEND, rtx_cnt==MAX_RTX → mode ZERO, next state FLUSH, rtx_abort_p.
  - FLUSH → mode ZERO.
  - tx_seqn=link_seqn[L]; tx_arqn=link_arqn[L]; tx_flow=rx_bufempty.
- RX, on rx_done_p, link L = rx_lt, only when rx_hecgood & rx_addressed (otherwise no per-link update):
  - link_flow_ok[L] ← rx_flow.
  - rx_arqn=1 with state PEND/FLUSH → link_seqn[L] toggles, state IDLE, rtx_cnt=0.
  - rx_data & rx_crcgood & rx_seqn≠link_seqn_old[L] → link_seqn_old[L]←rx_seqn, link_arqn[L]←1, rx_accept_p.
  - rx_data & rx_seqn==link_seqn_old[L] → link_arqn[L]←1, rx_ignore_p (CRC not checked).
  - rx_data & !rx_crcgood & new SEQN → link_arqn[L]←0.
  - rx_data=0 → link_arqn[L] unchanged.
- flush_p: PEND → FLUSH for flush_lt; ignored in IDLE/FLUSH.
- conn_new_p: link_arqn=0, link_seqn=1, link_seqn_old=1, link_flow_ok=1, IDLE, rtx_cnt=0 for conn_lt.
- Indices ≥ NLINK: event ignored.

## Timing
- Reset: tx_vld, tx_mode, tx_arqn, tx_seqn, tx_flow, rx_accept_p, rx_ignore_p, rtx_abort_p, rtx_abort_lt all 0. link_arqn=0, link_seqn=all 1, link_seqn_old=all 1, link_flow_ok=all 1. All states IDLE, counters 0.
- TX outputs, rtx_abort_p, and RX pulses are registered: they appear exactly 1 cycle after tx_hdr_p / rx_done_p, for 1 cycle. TX fields hold until the next tx_hdr_p.
- Per-link vectors update on the cycle after the triggering strobe.
- Same link in one cycle, priority: conn_new_p > RX ACK > flush_p > TX transition. TX outputs always use the pre-cycle state. If ACK and tx_hdr_p coincide, the next state is IDLE and the counter is cleared.
- Different links in the same cycle update independently.
- rst mid-operation: all state returns to reset values on the next edge; any pending pulses are dropped.

## Configuration
- ARQ_RTX_LIMIT_EN defined: rtx_cnt, MAX_RTX abort and rtx_abort_p/rtx_abort_lt are implemented as above.
- ARQ_RTX_LIMIT_EN undefined: no counter. PEND always retransmits with OLD, and only flush_p reaches FLUSH. rtx_abort_p and rtx_abort_lt are tied to 0.

## Test plan
- Reset, then tx_hdr_p link 2 with tx_data=1 → tx_mode=1, tx_seqn=1, tx_arqn=0 one cycle later; link 2 enters PEND.
- Link 2 in PEND; rx_done_p with hec ok, addressed, rx_arqn=1 → link_seqn[2]=0. Next tx_hdr_p gives tx_mode=1, tx_seqn=0.
- rx data on link 5, seqn=0, crc ok → rx_accept_p, link_seqn_old[5]=0, link_arqn[5]=1. Repeat same seqn with bad CRC → rx_ignore_p, arqn stays 1. seqn=1 with bad CRC → link_arqn[5]=0.
- ARQ_RTX_LIMIT_EN, MAX_RTX=2: NEW, OLD, OLD, then the 4th tx_hdr_p → tx_mode=3 with rtx_abort_p, rtx_abort_lt=tx_lt.
- flush_p and ACK on the same link in the same cycle → state IDLE, SEQN toggled. Later flush_p in PEND → next tx_mode=3.
- conn_new_p on link 1 during PEND with link_seqn[1]=0 → link 1 returns to IDLE, seqn 1, arqn 0; link 0 is unchanged.

Source files
------------

// File: rtl/arq_link_ctrl.sv
// Per-link ARQ / SEQN / flow-control engine between the header decoder and TX header builder.
// Optional retransmit limit is built when ARQ_RTX_LIMIT_EN is defined.
module arq_link_ctrl #(
   parameter int unsigned NLINK   = 8,
   parameter int unsigned LTW     = 3,
   parameter int unsigned RTXW    = 4,
   parameter int unsigned MAX_RTX = 15
) (
   input  logic             clk_6M,
   input  logic             rst,
   input  logic             conn_new_p,
   input  logic [LTW-1:0]   conn_lt,
   input  logic             tx_hdr_p,
   input  logic [LTW-1:0]   tx_lt,
   input  logic             tx_data,
   input  logic             rx_done_p,
   input  logic [LTW-1:0]   rx_lt,
   input  logic             rx_hecgood,
   input  logic             rx_crcgood,
   input  logic             rx_addressed,
   input  logic             rx_data,
   input  logic             rx_seqn,
   input  logic             rx_arqn,
   input  logic             rx_flow,
   input  logic             rx_bufempty,
   input  logic             flush_p,
   input  logic [LTW-1:0]   flush_lt,
   output logic             tx_vld,
   output logic [1:0]       tx_mode,
   output logic             tx_arqn,
   output logic             tx_seqn,
   output logic             tx_flow,
   output logic             rx_accept_p,
   output logic             rx_ignore_p,
   output logic             rtx_abort_p,
   output logic [LTW-1:0]   rtx_abort_lt,
   output logic [NLINK-1:0] link_arqn,
   output logic [NLINK-1:0] link_seqn,
   output logic [NLINK-1:0] link_seqn_old,
   output logic [NLINK-1:0] link_flow_ok
);

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FLUSH} link_st_e;
   typedef enum logic [1:0] {M_NONDATA, M_NEW, M_OLD, M_ZERO} tx_mode_e;

   if (MAX_RTX > (2 ** RTXW) - 1) begin : g_bad_max_rtx
      $error("MAX_RTX does not fit in RTXW bits");
   end

   link_st_e         st_q [NLINK];
   link_st_e         st_d [NLINK];
   logic [NLINK-1:0] arqn_q, arqn_d;
   logic [NLINK-1:0] seqn_q, seqn_d;
   logic [NLINK-1:0] old_q, old_d;
   logic [NLINK-1:0] flow_q, flow_d;

   logic             rx_ok;
   logic             tx_hit, rx_hit;
   link_st_e         sel_st;
   logic             sel_seqn, sel_arqn, sel_old;
   tx_mode_e         mode_d, tx_mode_q;
   logic             accept_d, ignore_d;

`ifdef ARQ_RTX_LIMIT_EN
   logic [RTXW-1:0]  cnt_q [NLINK];
   logic [RTXW-1:0]  cnt_d [NLINK];
   logic [RTXW-1:0]  sel_cnt;
   logic             abort_d;
   logic             abort_q;
   logic [LTW-1:0]   abort_lt_q;
`endif

   assign rx_ok = rx_done_p & rx_hecgood & rx_addressed;

   // Per-link next state; later assignments override earlier ones to realise
   // the priority conn_new > RX ACK > flush > TX transition.
   always_comb begin
      arqn_d = arqn_q;
      seqn_d = seqn_q;
      old_d  = old_q;
      flow_d = flow_q;
      for (int unsigned i = 0; i < NLINK; i++) begin
         st_d[i] = st_q[i];
`ifdef ARQ_RTX_LIMIT_EN
         cnt_d[i] = cnt_q[i];
`endif
         if (tx_hdr_p && tx_data && tx_lt == LTW'(i)) begin
            case (st_q[i])
               ST_IDLE: begin
                  st_d[i] = ST_PEND;
`ifdef ARQ_RTX_LIMIT_EN
                  cnt_d[i] = '0;
`endif
               end
               ST_PEND: begin
`ifdef ARQ_RTX_LIMIT_EN
                  if (cnt_q[i] < RTXW'(MAX_RTX)) cnt_d[i] = cnt_q[i] + 1'b1;
                  else                           st_d[i]  = ST_FLUSH;
`endif
               end
               default: ;
            endcase
         end
         if (flush_p && flush_lt == LTW'(i) && st_q[i] == ST_PEND) st_d[i] = ST_FLUSH;
         if (rx_ok && rx_lt == LTW'(i)) begin
            flow_d[i] = rx_flow;
            if (rx_arqn && st_q[i] != ST_IDLE) begin
               seqn_d[i] = ~seqn_q[i];
               st_d[i]   = ST_IDLE;
`ifdef ARQ_RTX_LIMIT_EN
               cnt_d[i]  = '0;
`endif
            end
            if (rx_data) begin
               if (rx_seqn == old_q[i]) begin
                  arqn_d[i] = 1'b1;
               end else if (rx_crcgood) begin
                  old_d[i]  = rx_seqn;
                  arqn_d[i] = 1'b1;
               end else begin
                  arqn_d[i] = 1'b0;
               end
            end
         end
         if (conn_new_p && conn_lt == LTW'(i)) begin
            arqn_d[i] = 1'b0;
            seqn_d[i] = 1'b1;
            old_d[i]  = 1'b1;
            flow_d[i] = 1'b1;
            st_d[i]   = ST_IDLE;
`ifdef ARQ_RTX_LIMIT_EN
            cnt_d[i]  = '0;
`endif
         end
      end
   end

   // TX and RX pulse decode, always from the pre-cycle link state.
   always_comb begin
      tx_hit   = 1'b0;
      rx_hit   = 1'b0;
      sel_st   = ST_IDLE;
      sel_seqn = 1'b0;
      sel_arqn = 1'b0;
      sel_old  = 1'b0;
`ifdef ARQ_RTX_LIMIT_EN
      sel_cnt  = '0;
      abort_d  = 1'b0;
`endif
      for (int unsigned i = 0; i < NLINK; i++) begin
         if (tx_lt == LTW'(i)) begin
            tx_hit   = tx_hdr_p;
            sel_st   = st_q[i];
            sel_seqn = seqn_q[i];
            sel_arqn = arqn_q[i];
`ifdef ARQ_RTX_LIMIT_EN
            sel_cnt  = cnt_q[i];
`endif
         end
         if (rx_lt == LTW'(i)) begin
            rx_hit  = rx_ok;
            sel_old = old_q[i];
         end
      end
      mode_d = M_NONDATA;
      if (tx_data) begin
         case (sel_st)
            ST_IDLE: mode_d = M_NEW;
            ST_PEND: begin
`ifdef ARQ_RTX_LIMIT_EN
               if (sel_cnt < RTXW'(MAX_RTX)) begin
                  mode_d = M_OLD;
               end else begin
                  mode_d  = M_ZERO;
                  abort_d = tx_hit;
               end
`else
               mode_d = M_OLD;
`endif
            end
            default: mode_d = M_ZERO;
         endcase
      end
      accept_d = rx_hit & rx_data & rx_crcgood & (rx_seqn != sel_old);
      ignore_d = rx_hit & rx_data & (rx_seqn == sel_old);
   end

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         tx_vld      <= 1'b0;
         tx_mode_q   <= M_NONDATA;
         tx_arqn     <= 1'b0;
         tx_seqn     <= 1'b0;
         tx_flow     <= 1'b0;
         rx_accept_p <= 1'b0;
         rx_ignore_p <= 1'b0;
         arqn_q      <= '0;
         seqn_q      <= '1;
         old_q       <= '1;
         flow_q      <= '1;
         for (int unsigned i = 0; i < NLINK; i++) st_q[i] <= ST_IDLE;
      end else begin
         tx_vld      <= tx_hit;
         rx_accept_p <= accept_d;
         rx_ignore_p <= ignore_d;
         if (tx_hit) begin
            tx_mode_q <= mode_d;
            tx_arqn   <= sel_arqn;
            tx_seqn   <= sel_seqn;
            tx_flow   <= rx_bufempty;
         end
         arqn_q <= arqn_d;
         seqn_q <= seqn_d;
         old_q  <= old_d;
         flow_q <= flow_d;
         for (int unsigned i = 0; i < NLINK; i++) st_q[i] <= st_d[i];
      end
   end

`ifdef ARQ_RTX_LIMIT_EN
   always_ff @(posedge clk_6M) begin
      if (rst) begin
         abort_q    <= 1'b0;
         abort_lt_q <= '0;
         for (int unsigned i = 0; i < NLINK; i++) cnt_q[i] <= '0;
      end else begin
         abort_q <= abort_d;
         if (abort_d) abort_lt_q <= tx_lt;
         for (int unsigned i = 0; i < NLINK; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign rtx_abort_p  = abort_q;
   assign rtx_abort_lt = abort_lt_q;
`else
   assign rtx_abort_p  = 1'b0;
   assign rtx_abort_lt = '0;
`endif

   assign tx_mode       = tx_mode_q;
   assign link_arqn     = arqn_q;
   assign link_seqn     = seqn_q;
   assign link_seqn_old = old_q;
   assign link_flow_ok  = flow_q;

endmodule
